tmds_channel_rx: RTL and testbench
==================================

# tmds_channel_rx

Receive-side counterpart of the DVI/TMDS transmit path: takes one TMDS channel's 10-bit raw words from an external 1:10 deserializer (arbitrary bit alignment), finds symbol alignment by hunting for control-token runs, and decodes each symbol to 8-bit video data, 2-bit control and a data-enable. Three instances (red, green, blue) sit in the pixclk domain between the deserializers and the video-timing recovery logic. On blue, `cd` carries `{vSync,hSync}`.

## Interface
Parameters:
- `LOCK_TOKENS`, 64: consecutive identical control tokens at the current offset required to declare lock.
- `SEARCH_TIMEOUT`, 1024: cycles spent at one offset in SEARCH before advancing. Must exceed one line period.
- `LOSS_TIMEOUT`, 4096: cycles allowed in LOCKED without a qualifying token run before lock is dropped.

Ports (one clock; reset is synchronous and active-high):
- `pixclk` in 1: symbol clock, one raw word per cycle.
- `rst` in 1: synchronous, active-high reset.
- `din` in 10: raw deserialized word. The first-received bit is in bit 0.
- `vd` out 8: decoded video data.
- `cd` out 2: decoded control bits.
- `vde` out 1: 1 when the current symbol is a data symbol.
- `locked` out 1: alignment acquired.
- `offset` out 4: current bit offset, 0..9.
- `relock_cnt` out 16: present only with `TMDS_RX_STATS_EN`.

## Operation
- Window: `win = {din, din_q}` (20 bits). The aligned symbol is `win[offset+9 : offset]`. The `din_q` register is 0 after reset.
- Control tokens:
  - 0x354 → `cd` = 00
  - 0x0AB → 01
  - 0x154 → 10
  - 0x2AB → 11
- Data decode of any other symbol `q`:
  - `t = q[9] ? ~q[7:0] : q[7:0]`
  - `d0 = t0`
  - `di = q[8] ? (ti ^ ti-1) : ~(ti ^ ti-1)`
- Run counter:
  - Increments while the aligned symbol is a control token equal to the previous aligned symbol.
  - Reloads to 1 on a different control token.
  - Clears on a data symbol.
  - Saturates at `LOCK_TOKENS`.
- FSM states: SEARCH (reset state) and LOCKED.
- SEARCH:
  - Timer counts cycles.
  - When the run counter reaches `LOCK_TOKENS` → LOCKED. The loss timer clears.
  - Else, when the timer reaches `SEARCH_TIMEOUT-1` → `offset` advances (9 wraps to 0). Timer and run counter clear.
  - Both conditions in the same cycle: lock wins and `offset` is unchanged.
- LOCKED:
  - `offset` is frozen.
  - The loss timer clears on every cycle where the run counter reaches `LOCK_TOKENS`.
  - When the loss timer reaches `LOSS_TIMEOUT-1` → SEARCH. `offset` advances (wrapping), and all counters clear.
- Output gating: while not locked, `vd`=0, `cd`=0 and `vde`=0. When locked:
  - control symbol → `vde`=0, `cd`=token value, `vd`=0
  - data symbol → `vde`=1, `vd`=decoded data, `cd` holds its last value

## Timing
- Reset values: `vd`=0, `cd`=0, `vde`=0, `locked`=0, `offset`=0, FSM=SEARCH, all counters 0, `relock_cnt`=0.
- Pipeline:
  - Stage 1 registers the aligned symbol.
  - Stage 2 registers the decoded outputs.
  - Latency is 2 pixclk edges from the cycle `din` carries the symbol's last bit to `vd`/`cd`/`vde`.
- `locked` is registered in stage 2 and aligned with the first gated-through symbol.
- `offset` changes take effect on the next window. Symbols already in the pipeline are discarded, because the gate stays off while not locked.
- `rst` asserted mid-operation returns everything to reset values on the next edge, regardless of state.

## Configuration
- `TMDS_RX_STATS_EN` defined:
  - Adds the `relock_cnt` port: a 16-bit saturating count of LOCKED→SEARCH transitions.
  - The count clears only on `rst`.
- Undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- Shared package `tmds_pkg`:
  - The four control-token constants, shared with the transmit encoder.
  - The `rx_state_t` enum (SEARCH, LOCKED).
- Sub-module `tmds_symbol_decode`: combinational. Takes a 10-bit symbol and produces `is_ctl`, `cd[1:0]` and `vd[7:0]`.
- The top level holds the window, offset mux, counters, FSM and output registers.

## Test plan
- **Reset:** hold `rst` 2 cycles with random `din` → all outputs 0, `offset`=0, `locked`=0.
- **Aligned lock:** 200 words of 0x354 at zero skew → `locked`=1 at cycle `LOCK_TOKENS`+2, `offset`=0, `cd`=00, `vde`=0.
- **Skewed lock:** `SEARCH_TIMEOUT`=128; serial stream of repeated 0x0AB shifted by 3 bits → `offset` steps 0→1→2→3 every 128 cycles, then `locked`=1 and `cd`=01.
- **Data decode:** while locked, send 0x100 then 0x2FF → `vde`=1, with `vd`=0x00 then 0xFE, each 2 cycles after input.
- **Lock loss:** after lock, send only 0x100 for `LOSS_TIMEOUT` cycles → `locked` drops to 0 and `offset` goes 0→1. Lock-vs-timeout coincidence in SEARCH → locks at the unchanged offset.
- **Stats (`TMDS_RX_STATS_EN`):** two forced lock losses → `relock_cnt`=2; `rst` → 0.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token encodings (also used by the transmit encoder)
// and the receive alignment FSM state type.
package tmds_pkg;

    localparam logic [9:0] TMDS_CTL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTL_11 = 10'h2AB;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } rx_state_t;

    function automatic logic tmds_is_ctl(input logic [9:0] sym);
        return (sym == TMDS_CTL_00) || (sym == TMDS_CTL_01) ||
               (sym == TMDS_CTL_10) || (sym == TMDS_CTL_11);
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: control-token detect plus 10b->8b video data decode.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_sym,
    output logic       o_is_ctl,
    output logic [1:0] o_cd,
    output logic [7:0] o_vd
);

    logic [7:0] w_t;

    assign w_t = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];

    always_comb begin
        o_vd    = '0;
        o_vd[0] = w_t[0];
        // q[8] selects XOR versus XNOR chaining of the transition-minimised byte
        for (int i = 1; i < 8; i++) begin
            o_vd[i] = i_sym[8] ? (w_t[i] ^ w_t[i-1]) : ~(w_t[i] ^ w_t[i-1]);
        end
        o_is_ctl = tmds_is_ctl(i_sym);
        case (i_sym)
            TMDS_CTL_01: o_cd = 2'b01;
            TMDS_CTL_10: o_cd = 2'b10;
            TMDS_CTL_11: o_cd = 2'b11;
            default:     o_cd = 2'b00;
        endcase
    end

endmodule

// File: rtl/tmds_channel_rx.sv
// One TMDS receive channel: word alignment by control-token run hunting, then 2-stage decode.
// Optional LOCKED->SEARCH statistics counter enabled by TMDS_RX_STATS_EN.
//
// state  | meaning
// SEARCH | dwelling at r_offset waiting for a token run; timer advances offset on expiry
// LOCKED | offset frozen; timer is the loss watchdog, cleared by every full token run
module tmds_channel_rx
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS    = 64,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic        pixclk,
    input  logic        rst,
    input  logic [9:0]  din,
    output logic [7:0]  vd,
    output logic [1:0]  cd,
    output logic        vde,
    output logic        locked,
    output logic [3:0]  offset
`ifdef TMDS_RX_STATS_EN
    ,
    output logic [15:0] relock_cnt
`endif
);

    localparam logic [15:0] LOCK_N      = 16'(LOCK_TOKENS);
    localparam logic [15:0] SEARCH_LAST = 16'(SEARCH_TIMEOUT - 1);
    localparam logic [15:0] LOSS_LAST   = 16'(LOSS_TIMEOUT - 1);

    rx_state_t   r_state;
    logic [9:0]  r_din_q;
    logic [9:0]  r_prev_sym;
    logic [9:0]  r_sym;
    logic [15:0] r_run;
    logic [15:0] r_timer;
    logic [3:0]  r_offset;
    logic [7:0]  r_vd;
    logic [1:0]  r_cd;
    logic        r_vde;
    logic        r_locked;

    logic [19:0] w_win;
    logic [9:0]  w_aligned;
    logic [15:0] w_run_next;
    logic        w_lock_hit;
    logic [3:0]  w_next_off;
    logic        w_is_ctl;
    logic [1:0]  w_cd;
    logic [7:0]  w_vd;

    // Older word sits in the low half, so bit 0 of the window is the earliest bit.
    assign w_win      = {din, r_din_q};
    assign w_aligned  = w_win[{1'b0, r_offset} +: 10];
    assign w_next_off = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
    assign w_lock_hit = (w_run_next == LOCK_N);

    always_comb begin
        w_run_next = '0;
        if (!tmds_is_ctl(w_aligned)) begin
            w_run_next = '0;
        end else if (w_aligned != r_prev_sym) begin
            w_run_next = 16'd1;
        end else if (r_run >= LOCK_N) begin
            w_run_next = LOCK_N;
        end else begin
            w_run_next = r_run + 16'd1;
        end
    end

`ifdef TMDS_RX_STATS_EN
    logic [15:0] r_relock;
    assign relock_cnt = r_relock;
`endif

    always_ff @(posedge pixclk) begin
        if (rst) begin
            r_state    <= SEARCH;
            r_din_q    <= '0;
            r_prev_sym <= '0;
            r_sym      <= '0;
            r_run      <= '0;
            r_timer    <= '0;
            r_offset   <= '0;
`ifdef TMDS_RX_STATS_EN
            r_relock   <= '0;
`endif
        end else begin
            r_din_q    <= din;
            r_prev_sym <= w_aligned;
            r_sym      <= w_aligned;
            case (r_state)
                SEARCH: begin
                    if (w_lock_hit) begin
                        r_state <= LOCKED;
                        r_timer <= '0;
                        r_run   <= w_run_next;
                    end else if (r_timer == SEARCH_LAST) begin
                        r_offset <= w_next_off;
                        r_timer  <= '0;
                        r_run    <= '0;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                        r_run   <= w_run_next;
                    end
                end
                LOCKED: begin
                    r_run <= w_run_next;
                    if (w_lock_hit) begin
                        r_timer <= '0;
                    end else if (r_timer == LOSS_LAST) begin
                        r_state  <= SEARCH;
                        r_offset <= w_next_off;
                        r_timer  <= '0;
                        r_run    <= '0;
`ifdef TMDS_RX_STATS_EN
                        if (r_relock != 16'hFFFF) r_relock <= r_relock + 16'd1;
`endif
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    tmds_symbol_decode u_dec (
        .i_sym    (r_sym),
        .o_is_ctl (w_is_ctl),
        .o_cd     (w_cd),
        .o_vd     (w_vd)
    );

    // Gate and lock flag share the same state sample so locked lines up with the first symbol out.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            r_vd     <= '0;
            r_cd     <= '0;
            r_vde    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_locked <= (r_state == LOCKED);
            if (r_state == LOCKED) begin
                if (w_is_ctl) begin
                    r_vde <= 1'b0;
                    r_vd  <= '0;
                    r_cd  <= w_cd;
                end else begin
                    r_vde <= 1'b1;
                    r_vd  <= w_vd;
                end
            end else begin
                r_vde <= 1'b0;
                r_vd  <= '0;
                r_cd  <= '0;
            end
        end
    end

    assign vd     = r_vd;
    assign cd     = r_cd;
    assign vde    = r_vde;
    assign locked = r_locked;
    assign offset = r_offset;

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Self-checking bench for tmds_channel_rx; exercises relock_cnt when TMDS_RX_STATS_EN is defined.
module tb_tmds_channel_rx;

    localparam int LT = 64;
    localparam int ST = 128;
    localparam int LS = 512;

    logic        pixclk = 1'b0;
    logic        rst    = 1'b1;
    logic [9:0]  din    = '0;
    logic [7:0]  vd;
    logic [1:0]  cd;
    logic        vde;
    logic        locked;
    logic [3:0]  offset;
`ifdef TMDS_RX_STATS_EN
    logic [15:0] relock_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         due;
        logic       vde;
        logic [7:0] vd;
        logic [1:0] cd;
    } exp_t;

    exp_t sb[$];

    tmds_channel_rx #(
        .LOCK_TOKENS    (LT),
        .SEARCH_TIMEOUT (ST),
        .LOSS_TIMEOUT   (LS)
    ) dut (
        .pixclk     (pixclk),
        .rst        (rst),
        .din        (din),
        .vd         (vd),
        .cd         (cd),
        .vde        (vde),
        .locked     (locked),
        .offset     (offset)
`ifdef TMDS_RX_STATS_EN
        ,
        .relock_cnt (relock_cnt)
`endif
    );

    always #5 pixclk = ~pixclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic is_tok(input logic [9:0] q);
        return q == 10'h354 || q == 10'h0AB || q == 10'h154 || q == 10'h2AB;
    endfunction

    function automatic logic [1:0] tok_cd(input logic [9:0] q);
        logic [1:0] r;
        case (q)
            10'h0AB: r = 2'b01;
            10'h154: r = 2'b10;
            10'h2AB: r = 2'b11;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] ref_vd(input logic [9:0] q);
        logic [7:0] t;
        logic [7:0] d;
        t    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++) d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        return d;
    endfunction

    // Raw word whose repeated serial stream places tok at window bit offset k.
    function automatic logic [9:0] rot_word(input logic [9:0] tok, input int k);
        logic [9:0] w;
        for (int j = 0; j < 10; j++) w[j] = tok[(j + 10 - k) % 10];
        return w;
    endfunction

    task automatic drive(input logic [9:0] w);
        din = w;
        @(posedge pixclk);
        @(negedge pixclk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(10'($urandom_range(0, 1023)));
        drive(10'($urandom_range(0, 1023)));
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (vd !== 8'h00)     begin n_fail++; $display("FAIL reset_vd got %h want 00", vd); end
        n_tests++; if (cd !== 2'b00)     begin n_fail++; $display("FAIL reset_cd got %b want 00", cd); end
        n_tests++; if (vde !== 1'b0)     begin n_fail++; $display("FAIL reset_vde got %b want 0", vde); end
        n_tests++; if (locked !== 1'b0)  begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
        n_tests++; if (offset !== 4'd0)  begin n_fail++; $display("FAIL reset_offset got %0d want 0", offset); end
    endtask

    task automatic test_aligned_lock();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            drive(10'h354);
            if (cyc == LT + 1) begin
                n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got %b want 0 at %0d", locked, cyc); end
            end
            if (cyc == LT + 2) begin
                n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_aligned got %b want 1 at %0d", locked, cyc); end
                n_tests++; if (offset !== 4'd0) begin n_fail++; $display("FAIL lock_offset got %0d want 0", offset); end
                n_tests++; if (cd !== 2'b00)    begin n_fail++; $display("FAIL lock_cd got %b want 00", cd); end
                n_tests++; if (vde !== 1'b0)    begin n_fail++; $display("FAIL lock_vde got %b want 0", vde); end
            end
        end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold got %b want 1", locked); end
    endtask

    // Locked at offset 0: the aligned symbol is the previous word, then two pipeline stages.
    task automatic test_data_decode();
        logic [9:0] stim[$];
        logic [1:0] last_cd;
        logic [9:0] w;
        exp_t       e;
        last_cd = 2'b00;
        stim = '{10'h354, 10'h100, 10'h2FF, 10'h0AB, 10'h2FF, 10'h154, 10'h100, 10'h2AB, 10'h354};
        for (int i = 0; i < 8; i++) begin
            do w = 10'($urandom_range(0, 1023)); while (is_tok(w));
            stim.push_back(w);
        end
        stim.push_back(10'h154);
        stim.push_back(10'h3C5);
        for (int i = 0; i < stim.size() + 6; i++) begin
            w = (i < stim.size()) ? stim[i] : 10'h354;
            if (i < stim.size()) begin
                e.due = cyc + 3;
                if (is_tok(w)) begin
                    e.vde = 1'b0; e.vd = 8'h00; e.cd = tok_cd(w); last_cd = e.cd;
                end else begin
                    e.vde = 1'b1; e.vd = ref_vd(w); e.cd = last_cd;
                end
                sb.push_back(e);
            end
            drive(w);
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                n_tests++; if (vde !== e.vde) begin n_fail++; $display("FAIL dec_vde got %b want %b at %0d", vde, e.vde, cyc); end
                n_tests++; if (vd !== e.vd)   begin n_fail++; $display("FAIL dec_vd got %h want %h at %0d", vd, e.vd, cyc); end
                n_tests++; if (cd !== e.cd)   begin n_fail++; $display("FAIL dec_cd got %b want %b at %0d", cd, e.cd, cyc); end
            end
        end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL dec_drain got %0d left want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_lock_loss();
        int d;
        int drop;
        for (int i = 0; i < 80; i++) drive(10'h354);
        d    = cyc;
        drop = -1;
        for (int i = 0; i < LS + 8; i++) begin
            drive(10'h100);
            if (cyc == d + 10) begin
                n_tests++; if (vde !== 1'b1 || vd !== 8'h00) begin n_fail++; $display("FAIL loss_data got vde=%b vd=%h want 1/00", vde, vd); end
            end
            if (cyc == d + LS) begin
                n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_early got %b want 1", locked); end
            end
            if (drop < 0 && locked === 1'b0) drop = cyc;
        end
        n_tests++; if (drop != d + LS + 2) begin n_fail++; $display("FAIL loss_edge got %0d want %0d", drop, d + LS + 2); end
        n_tests++; if (offset !== 4'd1) begin n_fail++; $display("FAIL loss_offset got %0d want 1", offset); end
        n_tests++; if (vde !== 1'b0 || cd !== 2'b00) begin n_fail++; $display("FAIL loss_gate got vde=%b cd=%b want 0/00", vde, cd); end

        // run completes in the same cycle the search timer expires
        do_reset();
        for (int i = 0; i < ST - LT - 1; i++) drive(10'h100);
        for (int i = 0; i < 80; i++) begin
            drive(10'h354);
            if (cyc == ST) begin
                n_tests++; if (offset !== 4'd0) begin n_fail++; $display("FAIL coinc_offset got %0d want 0", offset); end
            end
            if (cyc == ST + 1) begin
                n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL coinc_locked got %b want 1", locked); end
            end
        end
        n_tests++; if (offset !== 4'd0) begin n_fail++; $display("FAIL coinc_hold got %0d want 0", offset); end
    endtask

    task automatic test_skewed_lock();
        logic [9:0] w;
        int lock_at;
        do_reset();
        w       = rot_word(10'h0AB, 3);
        lock_at = -1;
        for (int i = 0; i < 700 && lock_at < 0; i++) begin
            drive(w);
            if (cyc == ST - 1) begin n_tests++; if (offset !== 4'd0) begin n_fail++; $display("FAIL skew_off0 got %0d want 0", offset); end end
            if (cyc == ST)     begin n_tests++; if (offset !== 4'd1) begin n_fail++; $display("FAIL skew_off1 got %0d want 1", offset); end end
            if (cyc == 2 * ST) begin n_tests++; if (offset !== 4'd2) begin n_fail++; $display("FAIL skew_off2 got %0d want 2", offset); end end
            if (cyc == 3 * ST) begin n_tests++; if (offset !== 4'd3) begin n_fail++; $display("FAIL skew_off3 got %0d want 3", offset); end end
            if (locked === 1'b1) lock_at = cyc;
        end
        n_tests++; if (lock_at != 3 * ST + LT + 1) begin n_fail++; $display("FAIL skew_lock_at got %0d want %0d", lock_at, 3 * ST + LT + 1); end
        n_tests++; if (cd !== 2'b01) begin n_fail++; $display("FAIL skew_cd got %b want 01", cd); end
        n_tests++; if (offset !== 4'd3) begin n_fail++; $display("FAIL skew_offset got %0d want 3", offset); end
        for (int i = 0; i < 2 * ST; i++) drive(w);
        n_tests++; if (offset !== 4'd3 || locked !== 1'b1) begin n_fail++; $display("FAIL skew_frozen got off=%0d lk=%b want 3/1", offset, locked); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        drive(10'h0AB);
        rst = 1'b0;
        n_tests++; if (locked !== 1'b0 || offset !== 4'd0) begin n_fail++; $display("FAIL mrst_state got lk=%b off=%0d want 0/0", locked, offset); end
        n_tests++; if (cd !== 2'b00 || vde !== 1'b0 || vd !== 8'h00) begin n_fail++; $display("FAIL mrst_out got cd=%b vde=%b vd=%h want 0", cd, vde, vd); end
    endtask

`ifdef TMDS_RX_STATS_EN
    task automatic test_stats();
        int guard;
        do_reset();
        n_tests++; if (relock_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_init got %0d want 0", relock_cnt); end
        for (int k = 0; k < 2; k++) begin
            guard = 0;
            while (locked !== 1'b1 && guard < 2000) begin drive(rot_word(10'h354, k)); guard++; end
            n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL stats_lock%0d got %b want 1", k, locked); end
            guard = 0;
            while (locked !== 1'b0 && guard < LS + 20) begin drive(10'h100); guard++; end
            n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stats_loss%0d got %b want 0", k, locked); end
        end
        n_tests++; if (relock_cnt !== 16'd2) begin n_fail++; $display("FAIL stats_count got %0d want 2", relock_cnt); end
        do_reset();
        n_tests++; if (relock_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_clear got %0d want 0", relock_cnt); end
    endtask
`endif

    initial begin
        @(negedge pixclk);
        test_reset();
        test_aligned_lock();
        test_data_decode();
        test_lock_loss();
        test_skewed_lock();
        test_mid_reset();
`ifdef TMDS_RX_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
